// File: rtl/pipe_pkg.sv
// Shared types and per-boundary constants for the core's inter-stage registers.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: stage state enum, payload widths and control kill masks per pipeline boundary.
package pipe_pkg;

  // The encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // IF/ID: pc + inst
  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  // ID/EX: pc, inst, rs1 data, rs2 data, imm
  localparam int IDEX_DATA_W  = 160;
  localparam int IDEX_CTRL_W  = 12;
  // EX/MEM: pc, alu result, rs2 data, rd index
  localparam int EXMEM_DATA_W = 101;
  localparam int EXMEM_CTRL_W = 8;
  // MEM/WB: pc, wb data, rd index
  localparam int MEMWB_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 3;

  // Every control bit is dropped on a bubble so no write enable leaks through.
  localparam logic [IFID_CTRL_W-1:0]  IFID_KILL_MASK  = '1;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_KILL_MASK  = '1;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_KILL_MASK = '1;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_KILL_MASK = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count updates on the edge after inc; clr wins over inc.
// Backpressure: none; holds at all-ones once saturated.
// Ports: clk, rst (async active-low), inc, clr, cnt[CNT_W].
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid, flush, bubble control masking and stall counter.
// Latency: 1 cycle in to out; 1 entry/cycle throughput.
// Backpressure: absorbs one extra entry on a downstream stall; in_ready comes from registered state only.
// Ports: clk, rst (async active-low), flush, in_valid/in_ready/in_data/in_ctrl,
//        out_valid/out_ready/out_data/out_ctrl, occupancy, stall_cnt, stat_clr.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W         = IDEX_DATA_W,
  parameter int                CTRL_W         = IDEX_CTRL_W,
  parameter logic [CTRL_W-1:0] CTRL_KILL_MASK = {CTRL_W{1'b1}},
  parameter int                CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stat_clr
);

  state_t            state;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic              in_acc;
  logic              out_acc;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign occupancy = state;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl & ~(out_valid ? {CTRL_W{1'b0}} : CTRL_KILL_MASK);

  // Flush only drops the valid state; payload registers keep stale contents,
  // which are harmless because control is masked while out_valid is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_acc) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (in_acc && out_acc) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
          end else if (in_acc) begin
            // Downstream stalled: park the newcomer behind the presented entry.
            skid_data <= in_data;
            skid_ctrl <= in_ctrl;
            state     <= FULL;
          end else if (out_acc) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_acc) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            state     <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_ready && !flush),
    .clr (stat_clr),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized self-checking bench for pipe_stage_skid against a queue-based reference model.
// Two instances share stimulus: default counter width and a 4-bit counter for saturation.
module tb_pipe_stage_skid;

  localparam int DATA_W = 160;
  localparam int CTRL_W = 12;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_ready = 1'b0;
  logic              stat_clr = 1'b0;

  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cnt;

  logic              in_ready4, out_valid4;
  logic [DATA_W-1:0] out_data4;
  logic [CTRL_W-1:0] out_ctrl4;
  logic [1:0]        occupancy4;
  logic [3:0]        stall_cnt4;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a FIFO of at most two entries plus an unbounded stall tally.
  ent_t q[$];
  int   stall_total = 0;

  always #5 clk = ~clk;

  pipe_stage_skid u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .stat_clr(stat_clr)
  );

  pipe_stage_skid #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .out_ctrl(out_ctrl4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4), .stat_clr(stat_clr)
  );

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Compare every visible output of both instances with the model.
  task automatic check_outputs();
    logic [CTRL_W-1:0] exp_ctrl;
    exp_ctrl = (q.size() > 0) ? q[0].c : '0;
    check_val("in_ready",   in_ready,   q.size() < 2);
    check_val("out_valid",  out_valid,  q.size() > 0);
    check_val("occupancy",  occupancy,  q.size());
    check_val("out_ctrl",   out_ctrl,   exp_ctrl);
    check_val("stall_cnt",  stall_cnt,  sat(stall_total, 65535));
    check_val("in_ready4",  in_ready4,  q.size() < 2);
    check_val("out_valid4", out_valid4, q.size() > 0);
    check_val("occupancy4", occupancy4, q.size());
    check_val("out_ctrl4",  out_ctrl4,  exp_ctrl);
    check_val("stall_cnt4", stall_cnt4, sat(stall_total, 15));
    if (q.size() > 0) begin
      check_val("out_data",  out_data,  q[0].d);
      check_val("out_data4", out_data4, q[0].d);
    end
  endtask

  // One clock: check, advance the model with the driven inputs, then clock.
  task automatic cyc();
    ent_t e;
    bit   ov;
    check_outputs();
    ov = q.size() > 0;
    if (stat_clr) stall_total = 0;
    else if (ov && !out_ready && !flush) stall_total++;
    if (flush) begin
      q.delete();
    end else begin
      bit in_acc;
      in_acc = in_valid && (q.size() < 2);
      if (ov && out_ready) void'(q.pop_front());
      if (in_acc) begin
        e.d = in_data;
        e.c = in_ctrl;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit fl, input bit sc);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    stat_clr  = sc;
    in_data   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    in_ctrl   = CTRL_W'($urandom);
    cyc();
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_in_ready"},  in_ready,  1'b1);
    check_val({tag, "_out_valid"}, out_valid, 1'b0);
    check_val({tag, "_out_data"},  out_data,  '0);
    check_val({tag, "_out_ctrl"},  out_ctrl,  '0);
    check_val({tag, "_occupancy"}, occupancy, 2'd0);
    check_val({tag, "_stall_cnt"}, stall_cnt, 16'd0);
    check_val({tag, "_stall4"},    stall_cnt4, 4'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] first_data;

    // Power-on reset, released away from the clock edge.
    repeat (2) @(posedge clk);
    #4 rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("reset");

    // First transfer: low byte AB, all-ones control.
    first_data        = {$urandom, $urandom, $urandom, $urandom, $urandom};
    first_data[7:0]   = 8'hAB;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = first_data;
    in_ctrl   = 12'hFFF;
    cyc();
    check_val("first_data", out_data, first_data);
    check_val("first_ctrl", out_ctrl, 12'hFFF);
    check_val("first_occ",  occupancy, 2'd1);

    // Free-flowing stream of 8 entries.
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_val("stream_stall", stall_cnt, 16'd0);

    // Downstream stall for 5 cycles mid-stream, then drain.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("stall_occ",   occupancy, 2'd2);
    check_val("stall_ready", in_ready,  1'b0);
    check_val("stall_cnt5",  stall_cnt, 16'd5);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("drained_occ", occupancy, 2'd0);

    // Fill to FULL, then flush with a same-cycle input and out_ready high.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("pre_flush_occ", occupancy, 2'd2);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check_val("flush_valid", out_valid, 1'b0);
    check_val("flush_occ",   occupancy, 2'd0);
    check_val("flush_ctrl",  out_ctrl,  '0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);

    // Counter saturation: one held entry, downstream stalled for 20 cycles.
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_val("sat_cnt4",  stall_cnt4, 4'd15);
    check_val("sat_cnt16", stall_cnt,  16'd20);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check_val("clr_cnt4",  stall_cnt4, 4'd0);
    check_val("clr_cnt16", stall_cnt,  16'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and counter clear.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 31) == 0), ($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset while FULL.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("pre_rst_occ", occupancy, 2'd2);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    stat_clr  = 1'b0;
    rst = 1'b0;
    #2;
    check_reset_values("midrst");
    check_val("midrst_occ4", occupancy4, 2'd0);
    q.delete();
    stall_total = 0;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Resume after reset and drain.
    for (int i = 0; i < 6; i++) drive(1'b1, ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("final_occ", occupancy, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
